// File: rtl/param_seq_detector_if.sv
// param_seq_detector_if: serial data, configuration and result signals of the pattern detector.
interface param_seq_detector_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               x;
    logic               x_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               z;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    modport master (
        output x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  z, match_count, cfg_err
    );

    modport slave (
        input  x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output z, match_count, cfg_err
    );
endinterface

// File: rtl/param_seq_detector.sv
// param_seq_detector: runtime-programmable serial pattern detector with valid qualifier and saturating match counter.
module param_seq_detector #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_0110,
    parameter logic [LEN_W-1:0]   RST_LEN     = 4
) (
    input logic clk,
    input logic reset,
    param_seq_detector_if.slave bus
);
    logic [MAX_LEN-1:0] hist, hist_n, pattern, mask;
    logic [LEN_W-1:0]   fill, fill_n, len;
    logic [CNT_W-1:0]   cnt;
    logic               overlap, z, cfg_err, match;

    // Only the low len bits of the history take part in the compare.
    always_comb begin
        hist_n = {hist[MAX_LEN-2:0], bus.x};
        fill_n = (fill == len) ? fill : fill + LEN_W'(1);
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = i < int'(len);
        match = (fill_n == len) && (((hist_n ^ pattern) & mask) == '0) && !cfg_err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist    <= '0;
            fill    <= '0;
            z       <= 1'b0;
            cnt     <= '0;
            cfg_err <= 1'b0;
            pattern <= RST_PATTERN;
            len     <= RST_LEN;
            overlap <= 1'b1;
        end else if (bus.cfg_load) begin
            hist    <= '0;
            fill    <= '0;
            z       <= 1'b0;
            cnt     <= '0;
            cfg_err <= (bus.cfg_len == '0) || (int'(bus.cfg_len) > MAX_LEN);
            pattern <= bus.cfg_pattern;
            len     <= bus.cfg_len;
            overlap <= bus.cfg_overlap;
        end else if (bus.x_valid) begin
            hist <= hist_n;
            fill <= (match && !overlap) ? '0 : fill_n;
            z    <= match;
            cnt  <= (match && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
        end else begin
            z <= 1'b0;
        end
    end

    assign bus.z           = z;
    assign bus.match_count = cnt;
    assign bus.cfg_err     = cfg_err;
endmodule

// File: tb/tb_param_seq_detector.sv
// tb_param_seq_detector: directed scenarios plus random traffic against a bit-queue reference model.
module tb_param_seq_detector;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_checks = 0;
    int n_errors = 0;
    int zc;

    param_seq_detector_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) bus ();
    param_seq_detector_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) bus2 ();

    assign bus2.x           = bus.x;
    assign bus2.x_valid     = bus.x_valid;
    assign bus2.cfg_load    = bus.cfg_load;
    assign bus2.cfg_pattern = bus.cfg_pattern;
    assign bus2.cfg_len     = bus.cfg_len;
    assign bus2.cfg_overlap = bus.cfg_overlap;

    param_seq_detector #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    param_seq_detector #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

    always #5 clk = ~clk;

    // Reference: the bits received since the last restart, newest at the back.
    logic [7:0] m_pat;
    int         m_len, ecnt, ecnt2;
    bit         m_ov, m_err, ez;
    bit         q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat = 8'b0000_0110;
        m_len = 4;
        m_ov  = 1'b1;
        m_err = 1'b0;
        q.delete();
        ez    = 1'b0;
        ecnt  = 0;
        ecnt2 = 0;
    endtask

    task automatic model_edge();
        bit hit;
        if (bus.cfg_load) begin
            m_pat = bus.cfg_pattern;
            m_len = int'(bus.cfg_len);
            m_ov  = bus.cfg_overlap;
            m_err = (m_len == 0) || (m_len > 8);
            q.delete();
            ez    = 1'b0;
            ecnt  = 0;
            ecnt2 = 0;
        end else if (bus.x_valid) begin
            q.push_back(bus.x);
            hit = !m_err && (q.size() >= m_len);
            for (int k = 0; k < m_len; k++)
                if (hit && q[q.size()-1-k] != m_pat[k]) hit = 1'b0;
            ez = hit;
            if (hit) begin
                ecnt  = (ecnt < 255) ? ecnt + 1 : 255;
                ecnt2 = (ecnt2 < 3) ? ecnt2 + 1 : 3;
                if (!m_ov) q.delete();
            end
            if (q.size() > 16) void'(q.pop_front());
        end else begin
            ez = 1'b0;
        end
    endtask

    task automatic step(input bit xi, input bit vi, input bit li);
        bus.x        = xi;
        bus.x_valid  = vi;
        bus.cfg_load = li;
        @(posedge clk);
        model_edge();
        #1;
        check("z", bus.z, ez);
        check("cnt", bus.match_count, ecnt);
        check("cnt_sat", bus2.match_count, ecnt2);
        check("err", bus.cfg_err, m_err);
        check("z_sat", bus2.z, ez);
        if (bus.z) zc++;
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ov);
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ov;
        step(1'b1, 1'b1, 1'b1);
        zc = 0;
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0);
    endtask

    task automatic mid_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_z", bus.z, 0);
        check("rst_cnt", bus.match_count, 0);
        check("rst_err", bus.cfg_err, 0);
        model_reset();
        #1 reset = 1'b1;
    endtask

    initial begin
        bus.x = 1'b0; bus.x_valid = 1'b0; bus.cfg_load = 1'b0;
        bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
        model_reset();
        #12;
        check("reset_z", bus.z, 0);
        check("reset_cnt", bus.match_count, 0);
        check("reset_err", bus.cfg_err, 0);
        reset = 1'b1;
        zc = 0;

        // 1: defaults, overlapping
        feed(16'b0011_0110_0110, 12);
        check("s1_pulses", zc, 3);
        check("s1_cnt", bus.match_count, 3);

        // 2: non-overlapping suppresses the shared-bit match
        load(8'b0110, 4'd4, 1'b0);
        feed(16'b0011_0110_0110, 12);
        check("s2_pulses", zc, 2);
        check("s2_cnt", bus.match_count, 2);

        // 3: stalls inside the pattern
        load(8'b0110, 4'd4, 1'b1);
        feed(16'b01, 2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check("s3_stall_pulses", zc, 0);
        feed(16'b10, 2);
        check("s3_z", bus.z, 1);
        step(1'b0, 1'b0, 1'b0);
        check("s3_pulses", zc, 1);

        // 4: length 1, then invalid lengths
        load(8'b1, 4'd1, 1'b1);
        feed(16'b111, 3);
        check("s4_pulses", zc, 3);
        check("s4_cnt", bus.match_count, 3);
        load(8'hff, 4'd0, 1'b1);
        feed(16'hffff, 10);
        check("s4_len0_err", bus.cfg_err, 1);
        check("s4_len0_pulses", zc, 0);
        load(8'h00, 4'd9, 1'b1);
        feed(16'h0000, 12);
        check("s4_len9_err", bus.cfg_err, 1);
        check("s4_len9_pulses", zc, 0);

        // 5: async reset mid-stream, and cfg_load beating x_valid
        load(8'b0110, 4'd4, 1'b1);
        feed(16'b0110, 4);
        check("s5_z_before", bus.z, 1);
        mid_reset();
        feed(16'b011, 3);
        mid_reset();
        zc = 0;
        step(1'b0, 1'b1, 1'b0);
        check("s5_lone0", zc, 0);
        feed(16'b110, 3);
        check("s5_full", zc, 1);
        load(8'b1, 4'd1, 1'b1);
        check("s5_load_discard", bus.z, 0);

        // 6: saturation of the narrow counter
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check("s6_sat", bus2.match_count, (i < 3) ? i + 1 : 3);
        end
        check("s6_pulses", zc, 6);

        // random traffic with occasional reprogramming and resets
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3)
                load(8'($urandom), ($urandom_range(0, 9) < 7) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 10)), 1'($urandom));
            else if (r == 3)
                mid_reset();
            else
                step(1'($urandom), $urandom_range(0, 3) != 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
